// File: rtl/video_sync_decoder_if.sv
// Pixel-stream bundle as driven onto display pins: sync, data enable and 8-bit RGB.
// The source side owns every signal; the decoder only observes.
interface video_sync_decoder_if;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    modport master (
        output hsync,
        output vsync,
        output de,
        output r,
        output g,
        output b
    );

    modport slave (
        input hsync,
        input vsync,
        input de,
        input r,
        input g,
        input b
    );
endinterface

// File: rtl/video_sync_decoder.sv
// Receive-side video decoder: rebuilds sx/sy from de and vsync, measures active geometry, locks.
// Optional macro FRAME_CHECKSUM_EN adds a per-frame (r+g+b) checksum on frame_sum/sum_valid.
module video_sync_decoder #(
    parameter int unsigned CORDW       = 10,
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter bit          SYNC_ACT    = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                clk_pix,
    input  logic                rst_pix,
    video_sync_decoder_if.slave vid,
    output logic [CORDW-1:0]    out_sx,
    output logic [CORDW-1:0]    out_sy,
    output logic                out_de,
    output logic [7:0]          out_r,
    output logic [7:0]          out_g,
    output logic [7:0]          out_b,
    output logic                line_start,
    output logic                frame_start,
    output logic                locked,
    output logic                timing_err,
`ifdef FRAME_CHECKSUM_EN
    output logic [15:0]         frame_sum,
    output logic                sum_valid,
`endif
    output logic [CORDW-1:0]    meas_w,
    output logic [CORDW-1:0]    meas_h
);

    typedef enum logic [1:0] {StIdle, StMeasure, StLocked} state_e;

    localparam logic [CORDW-1:0] CntMax     = {CORDW{1'b1}};
    localparam logic [CORDW-1:0] HRes       = CORDW'(H_RES);
    localparam logic [CORDW-1:0] VRes       = CORDW'(V_RES);
    localparam logic [3:0]       LockFrames = 4'(LOCK_FRAMES);

    // Registered copies of the sync/enable pins for edge detection
    logic vs_q;
    logic de_q;

    logic [CORDW-1:0] sx_q, sx_d;
    logic [CORDW-1:0] sy_q, sy_d;
    logic [CORDW-1:0] line_cnt_q, line_cnt_d;
    logic             first_line_q, first_line_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;
    logic [CORDW-1:0] meas_w_q, meas_w_d;
    logic [CORDW-1:0] meas_h_q, meas_h_d;
    logic             frame_bad_q, frame_bad_d;
    logic             out_de_q;
    logic [7:0]       out_r_q, out_g_q, out_b_q;

    state_e           state_q, state_d;
    logic [3:0]       good_q, good_d;
    logic             err_q, err_d;

    logic             vs_edge;
    logic             de_rise;
    logic             de_fall;
    logic [CORDW-1:0] run_len;
    logic [CORDW-1:0] line_base;
    logic             width_bad;
    logic             frame_is_bad;

    assign vs_edge = (vid.vsync == SYNC_ACT) && (vs_q != SYNC_ACT);
    assign de_rise = vid.de && !de_q;
    assign de_fall = !vid.de && de_q;

    // sx holds the last index of the run, so the run length is one more (saturating)
    assign run_len   = (sx_q == CntMax) ? CntMax : sx_q + 1'b1;
    assign width_bad = (run_len != HRes);
    assign line_base = vs_edge ? '0 : line_cnt_q;

    // A bad width closing in the same cycle as vsync is judged with this frame
    assign frame_is_bad = frame_bad_q || (de_fall && width_bad) || (line_cnt_q != VRes);

    always_comb begin
        sx_d         = sx_q;
        sy_d         = sy_q;
        line_cnt_d   = line_cnt_q;
        first_line_d = first_line_q;
        ls_d         = 1'b0;
        fs_d         = 1'b0;
        meas_w_d     = meas_w_q;
        meas_h_d     = meas_h_q;
        frame_bad_d  = frame_bad_q;

        if (vs_edge) begin
            line_cnt_d   = '0;
            first_line_d = 1'b1;
            meas_h_d     = line_cnt_q;
            frame_bad_d  = 1'b0;
        end

        if (de_rise) begin
            sx_d       = '0;
            ls_d       = 1'b1;
            line_cnt_d = (line_base == CntMax) ? CntMax : line_base + 1'b1;
            if (first_line_d) begin
                sy_d         = '0;
                fs_d         = 1'b1;
                first_line_d = 1'b0;
            end else if (sy_q != CntMax) begin
                sy_d = sy_q + 1'b1;
            end
        end else if (vid.de && (sx_q != CntMax)) begin
            sx_d = sx_q + 1'b1;
        end

        if (de_fall) begin
            meas_w_d = run_len;
            if (width_bad && !vs_edge) begin
                frame_bad_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;

        if (de_fall && width_bad && (state_q == StLocked)) begin
            err_d = 1'b1;
        end

        if (vs_edge) begin
            unique case (state_q)
                StIdle: begin
                    // The frame before the first vsync is partial and never judged
                    state_d = StMeasure;
                    good_d  = '0;
                end
                StMeasure: begin
                    if (frame_is_bad) begin
                        good_d = '0;
                    end else begin
                        good_d = good_q + 4'd1;
                        if (good_d >= LockFrames) begin
                            state_d = StLocked;
                        end
                    end
                end
                StLocked: begin
                    if (frame_is_bad) begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = StMeasure;
                    end
                end
                default: begin
                    state_d = StIdle;
                    good_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            // Resetting to the active level keeps a vsync held through reset from faking an edge
            vs_q         <= SYNC_ACT;
            de_q         <= 1'b0;
            sx_q         <= '0;
            sy_q         <= '0;
            line_cnt_q   <= '0;
            first_line_q <= 1'b0;
            ls_q         <= 1'b0;
            fs_q         <= 1'b0;
            meas_w_q     <= '0;
            meas_h_q     <= '0;
            frame_bad_q  <= 1'b0;
            out_de_q     <= 1'b0;
            out_r_q      <= '0;
            out_g_q      <= '0;
            out_b_q      <= '0;
            state_q      <= StIdle;
            good_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            vs_q         <= vid.vsync;
            de_q         <= vid.de;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            line_cnt_q   <= line_cnt_d;
            first_line_q <= first_line_d;
            ls_q         <= ls_d;
            fs_q         <= fs_d;
            meas_w_q     <= meas_w_d;
            meas_h_q     <= meas_h_d;
            frame_bad_q  <= frame_bad_d;
            out_de_q     <= vid.de;
            out_r_q      <= vid.r;
            out_g_q      <= vid.g;
            out_b_q      <= vid.b;
            state_q      <= state_d;
            good_q       <= good_d;
            err_q        <= err_d;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] sum_q, sum_d;
    logic        sv_q, sv_d;
    logic [15:0] pix_sum;

    assign pix_sum = {8'd0, vid.r} + {8'd0, vid.g} + {8'd0, vid.b};

    // A pixel coinciding with the vsync edge belongs to the new frame
    always_comb begin
        acc_d = acc_q;
        sum_d = sum_q;
        sv_d  = 1'b0;
        if (vs_edge) begin
            sum_d = acc_q;
            sv_d  = (state_q != StIdle);
            acc_d = vid.de ? pix_sum : 16'd0;
        end else if (vid.de) begin
            acc_d = acc_q + pix_sum;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            acc_q <= '0;
            sum_q <= '0;
            sv_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
            sv_q  <= sv_d;
        end
    end

    assign frame_sum = sum_q;
    assign sum_valid = sv_q;
`endif

    assign out_sx      = sx_q;
    assign out_sy      = sy_q;
    assign out_de      = out_de_q;
    assign out_r       = out_r_q;
    assign out_g       = out_g_q;
    assign out_b       = out_b_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign locked      = (state_q == StLocked);
    assign timing_err  = err_q;
    assign meas_w      = meas_w_q;
    assign meas_h      = meas_h_q;

endmodule

// File: tb/tb_video_sync_decoder.sv
// Scoreboard bench for video_sync_decoder on a shrunk 20x6 active / 28x10 total raster.
// The driver queues expected pixels, widths and frame verdicts; a negedge monitor checks them.
module tb_video_sync_decoder;

    localparam int H     = 20;
    localparam int V     = 6;
    localparam int LINE  = 28;
    localparam int CORDW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_sync_decoder_if vif ();

    logic [CORDW-1:0] out_sx, out_sy, meas_w, meas_h;
    logic             out_de, line_start, frame_start, locked, timing_err;
    logic [7:0]       out_r, out_g, out_b;
`ifdef FRAME_CHECKSUM_EN
    logic [15:0]      frame_sum;
    logic             sum_valid;
`endif

    video_sync_decoder #(
        .CORDW       (CORDW),
        .H_RES       (H),
        .V_RES       (V),
        .SYNC_ACT    (1'b0),
        .LOCK_FRAMES (2)
    ) dut (
        .clk_pix     (clk),
        .rst_pix     (rst),
        .vid         (vif.slave),
        .out_sx      (out_sx),
        .out_sy      (out_sy),
        .out_de      (out_de),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .line_start  (line_start),
        .frame_start (frame_start),
        .locked      (locked),
        .timing_err  (timing_err),
`ifdef FRAME_CHECKSUM_EN
        .frame_sum   (frame_sum),
        .sum_valid   (sum_valid),
`endif
        .meas_w      (meas_w),
        .meas_h      (meas_h)
    );

    typedef struct packed {
        logic [9:0]  sx;
        logic [9:0]  sy;
        logic [23:0] rgb;
        logic        ls;
        logic        fs;
        logic        chk_sy;
    } pix_t;

    typedef struct packed {
        logic [9:0] w;
        logic       err;
    } wid_t;

    typedef struct packed {
        logic [9:0]  h;
        logic        lk;
        logic        err;
        logic        sv;
        logic        cs;
        logic [15:0] sum;
    } frm_t;

    pix_t pix_q[$];
    wid_t wid_q[$];
    frm_t frm_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    logic vs_prev = 1'b1;
    logic vs_evt = 1'b0;
    logic prev_de = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] colour(input int x, input int y, input bit cs);
        if (cs) begin
            return (x >= 5 && x <= 7 && y >= 2 && y <= 4) ? 24'hFFFFFF : 24'h113377;
        end
        return {8'(x), 8'(y + 64), 8'(x) ^ 8'hA5};
    endfunction

    task automatic drive(input bit hs, input bit vs, input bit de, input logic [23:0] c);
        vif.hsync = hs;
        vif.vsync = vs;
        vif.de    = de;
        vif.r     = c[23:16];
        vif.g     = c[15:8];
        vif.b     = c[7:0];
        @(posedge clk);
        #1;
    endtask

    task automatic active_line(input int w, input int y, input bit sy_chk, input bit cs,
                               input bit err);
        pix_t p;
        wid_t e;
        e.w   = 10'(w);
        e.err = err;
        wid_q.push_back(e);
        for (int x = 0; x < LINE; x++) begin
            if (x < w) begin
                p.sx     = 10'(x);
                p.sy     = 10'(y);
                p.rgb    = colour(x, y, cs);
                p.ls     = (x == 0);
                p.fs     = (x == 0) && (y == 0);
                p.chk_sy = sy_chk;
                pix_q.push_back(p);
                drive(1'b1, 1'b1, 1'b1, p.rgb);
            end else begin
                drive(!(x >= 22 && x < 26), 1'b1, 1'b0, 24'h0);
            end
        end
    endtask

    task automatic blank_line(input bit vs_on);
        for (int x = 0; x < LINE; x++) begin
            drive(!(x >= 22 && x < 26), !vs_on, 1'b0, 24'h0);
        end
    endtask

    // Active lines first, then four blanking lines with vsync asserted on the second
    task automatic frame(input int nl, input int bad_line, input int bad_w, input bit sy_chk,
                         input bit cs, input bit lk, input bit err, input bit sv);
        frm_t f;
        for (int l = 0; l < nl; l++) begin
            active_line((l == bad_line) ? bad_w : H, l, sy_chk, cs, l == bad_line);
        end
        blank_line(1'b0);
        f.h   = 10'(nl);
        f.lk  = lk;
        f.err = err;
        f.sv  = sv;
        f.cs  = cs;
        f.sum = 16'h6BFA;
        frm_q.push_back(f);
        blank_line(1'b1);
        blank_line(1'b0);
        blank_line(1'b0);
    endtask

    always @(posedge clk) begin
        vs_evt  <= vs_prev && !vif.vsync;
        vs_prev <= vif.vsync;
    end

    task automatic monitor_step();
        pix_t p, a;
        wid_t w;
        frm_t f;
        bit   evt;
        bit   exp_err;
        evt     = 1'b0;
        exp_err = 1'b0;
        if (out_de) begin
            if (pix_q.size() == 0) begin
                check("pixel_unexpected", 64'(out_sx), 64'hFFFF);
            end else begin
                p        = pix_q.pop_front();
                a.sx     = out_sx;
                a.sy     = p.chk_sy ? out_sy : p.sy;
                a.rgb    = {out_r, out_g, out_b};
                a.ls     = line_start;
                a.fs     = p.chk_sy ? frame_start : p.fs;
                a.chk_sy = p.chk_sy;
                check("pixel", 64'(a), 64'(p));
            end
        end
        if (prev_de && !out_de) begin
            evt = 1'b1;
            if (wid_q.size() == 0) begin
                check("width_unexpected", 64'(meas_w), 64'hFFFF);
            end else begin
                w = wid_q.pop_front();
                check("meas_w", 64'(meas_w), 64'(w.w));
                exp_err |= w.err;
            end
        end
        if (vs_evt) begin
            evt = 1'b1;
            if (frm_q.size() == 0) begin
                check("frame_unexpected", 64'(meas_h), 64'hFFFF);
            end else begin
                f = frm_q.pop_front();
                check("meas_h", 64'(meas_h), 64'(f.h));
                check("locked", 64'(locked), 64'(f.lk));
                exp_err |= f.err;
`ifdef FRAME_CHECKSUM_EN
                check("sum_valid", 64'(sum_valid), 64'(f.sv));
                if (f.cs) begin
                    check("frame_sum", 64'(frame_sum), 64'(f.sum));
                end
`endif
            end
        end
        if (evt) begin
            check("timing_err", 64'(timing_err), 64'(exp_err));
        end else if (timing_err) begin
            check("timing_err_spurious", 64'(timing_err), 64'd0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                monitor_step();
            end
            prev_de = out_de;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vif.hsync = 1'b1;
        vif.vsync = 1'b1;
        vif.de    = 1'b0;
        vif.r     = 8'd0;
        vif.g     = 8'd0;
        vif.b     = 8'd0;
        rst       = 1'b1;
        repeat (3) drive(1'b1, 1'b1, 1'b0, 24'h0);
        rst = 1'b0;

        // Reset in the middle of a long de run
        for (int i = 0; i < 301; i++) begin
            drive(1'b1, 1'b1, 1'b1, {8'(i), 8'(i + 1), 8'(i + 2)});
        end
        @(negedge clk);
        check("sx_before_reset", 64'(out_sx), 64'd300);
        check("rgb_latency", 64'({out_r, out_g, out_b}), 64'h2C2D2E);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'({out_sx, out_sy, out_de, out_r, out_g, out_b, line_start, frame_start, locked,
                   timing_err}), 64'd0);
        check("reset_meas", 64'({meas_w, meas_h}), 64'd0);
`ifdef FRAME_CHECKSUM_EN
        check("reset_sum", 64'({frame_sum, sum_valid}), 64'd0);
`endif
        rst    = 1'b0;
        vif.de = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Partial frame (discarded by IDLE), then two good frames lock at the third vsync
        frame(V, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(V, -1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(V, -1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        // Short line while locked: error at de fall, again at vsync, then re-lock
        frame(V, 2, H - 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        frame(V, -1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(V, -1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        // One active line short while locked
        frame(V - 1, -1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        // Checksum pattern: 120 pixels of 0x11+0x33+0x77 with a 3x3 white square -> 0x6BFA
        frame(V, -1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Saturation: de held for 1100 cycles stops sx at 1023
        begin
            pix_t p;
            wid_t e;
            e.w   = 10'd1023;
            e.err = 1'b0;
            wid_q.push_back(e);
            for (int i = 0; i < 1100; i++) begin
                p.sx     = (i > 1023) ? 10'd1023 : 10'(i);
                p.sy     = 10'd0;
                p.rgb    = colour(i, 0, 1'b0);
                p.ls     = (i == 0);
                p.fs     = (i == 0);
                p.chk_sy = 1'b1;
                pix_q.push_back(p);
                drive(1'b1, 1'b1, 1'b1, p.rgb);
            end
        end
        repeat (30) drive(1'b1, 1'b1, 1'b0, 24'h0);

        check("queues_drained", 64'(pix_q.size() + wid_q.size() + frm_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
